// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg
//   Shared types and constants for the HD44780 4-bit write sequencer.
//   Holds the FSM state enum, the default timing values (in clk cycles),
//   the clear/home detect constant and the init nibble table.
//   Optional macro: LCD_SEQ_INIT_EN adds the power-on init states.
package lcd_seq_pkg;

   localparam int unsigned CNT_W   = 20;
   localparam int unsigned CNT_MAX = 1 << CNT_W;

   localparam int unsigned DEF_CLK_HZ = 27_000_000;
   localparam int unsigned DEF_T_SU   = 2;
   localparam int unsigned DEF_T_EH   = 8;
   localparam int unsigned DEF_T_NIB  = 27;
   localparam int unsigned DEF_T_CMD  = 1080;
   localparam int unsigned DEF_T_CLR  = 44280;
   localparam int unsigned DEF_T_PWR  = 405000;
   localparam int unsigned DEF_T_INIT = 110700;

   // Clear display (0x01) and return home (0x02/0x03) share DB[7:2] == 0.
   localparam logic [5:0] CLR_HOME_HI = 6'b00_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SU   = 3'd1,
      ST_EH   = 3'd2,
      ST_GAP  = 3'd3,
      ST_WAIT = 3'd4
`ifdef LCD_SEQ_INIT_EN
      ,
      ST_PWR  = 3'd5,
      ST_INIT = 3'd6
`endif
   } lcd_state_e;

   function automatic logic is_clr_home(input logic rs, input logic [7:0] d);
      return !rs && (d[7:2] == CLR_HOME_HI);
   endfunction

`ifdef LCD_SEQ_INIT_EN
   localparam int unsigned INIT_NIBS = 4;

   // Init sequence is 0x3, 0x3, 0x3, 0x2.
   function automatic logic [3:0] init_nib(input logic [1:0] idx);
      return (idx == 2'(INIT_NIBS - 1)) ? 4'h2 : 4'h3;
   endfunction
`endif

endpackage

// File: rtl/lcd_seq_if.sv
// lcd_seq_if
//   Byte request handshake between a host and lcd_seq.
//   req   : byte transfer request (host -> sequencer)
//   rs_in : register select for the byte, 0 = command, 1 = data
//   data  : byte to send
//   ready : sequencer idle; a byte is taken when req && ready
interface lcd_seq_if;
   logic       req;
   logic       rs_in;
   logic [7:0] data;
   logic       ready;

   modport master (output req, output rs_in, output data, input ready);
   modport slave  (input req, input rs_in, input data, output ready);
endinterface

// File: rtl/lcd_nib_tx.sv
// lcd_nib_tx
//   Registered HD44780 pin driver for one nibble strobe. The sequencer
//   presents the nibble and RS when setup begins (load) and raises strobe
//   for the enable-high window; RS/DB only change on load, so they are held
//   across the enable fall until the next setup.
//   Ports: clk, rst (sync, active high), load, rs_nxt, nib_nxt, strobe,
//          lcd_e, lcd_rs, lcd_db.
module lcd_nib_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       rs_nxt,
   input  logic [3:0] nib_nxt,
   input  logic       strobe,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [3:0] lcd_db
);

   always_ff @(posedge clk) begin
      if (rst) begin
         lcd_e  <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_db <= 4'h0;
      end else begin
         lcd_e <= strobe;
         if (load) begin
            lcd_rs <= rs_nxt;
            lcd_db <= nib_nxt;
         end
      end
   end

endmodule

// File: rtl/lcd_seq.sv
// lcd_seq
//   HD44780 4-bit write-only sequencer. Each accepted byte is sent as a high
//   then a low nibble (setup, enable high, gap), followed by a post-byte wait
//   that is longer for clear/home commands. One 20-bit down-counter times
//   every state; loading N-1 on entry gives exactly N cycles in the state.
//   Optional macro LCD_SEQ_INIT_EN: after reset wait T_PWR, then send init
//   nibbles 0x3, 0x3, 0x3, 0x2 (rs = 0), each followed by T_INIT.
//   Ports: clk, rst (sync, active high), host (lcd_seq_if.slave),
//          lcd_e, lcd_rw (tied 0), lcd_rs, lcd_db[3:0] (DB7..DB4).
//
//   state | meaning
//   IDLE  | ready, waiting for req
//   SU    | RS/DB setup, lcd_e low
//   EH    | lcd_e high
//   GAP   | between high and low nibble, lcd_e low
//   WAIT  | post-byte execution wait
//   PWR   | power-on wait (init build only)
//   INIT  | wait after an init nibble (init build only)
module lcd_seq
   import lcd_seq_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEF_CLK_HZ,
   parameter int unsigned T_SU   = DEF_T_SU,
   parameter int unsigned T_EH   = DEF_T_EH,
   parameter int unsigned T_NIB  = DEF_T_NIB,
   parameter int unsigned T_CMD  = DEF_T_CMD,
   parameter int unsigned T_CLR  = DEF_T_CLR,
   parameter int unsigned T_PWR  = DEF_T_PWR,
   parameter int unsigned T_INIT = DEF_T_INIT
) (
   input  logic       clk,
   input  logic       rst,
   lcd_seq_if.slave   host,
   output logic       lcd_e,
   output logic       lcd_rw,
   output logic       lcd_rs,
   output logic [3:0] lcd_db
);

   if (CLK_HZ == 0) begin : g_bad_clk
      $error("lcd_seq: CLK_HZ must be nonzero");
   end
   if (T_SU == 0 || T_EH == 0 || T_NIB == 0 || T_CMD == 0 ||
       T_CLR == 0 || T_PWR == 0 || T_INIT == 0) begin : g_bad_zero
      $error("lcd_seq: timing parameters must be at least 1");
   end
   if (T_CMD > CNT_MAX || T_CLR > CNT_MAX || T_PWR > CNT_MAX ||
       T_INIT > CNT_MAX) begin : g_bad_range
      $error("lcd_seq: timing parameter exceeds counter range");
   end

   localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
   localparam logic [CNT_W-1:0] LD_EH  = CNT_W'(T_EH - 1);
   localparam logic [CNT_W-1:0] LD_NIB = CNT_W'(T_NIB - 1);
   localparam logic [CNT_W-1:0] LD_CMD = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(T_CLR - 1);
`ifdef LCD_SEQ_INIT_EN
   localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(T_PWR - 1);
   localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(T_INIT - 1);
   localparam lcd_state_e       ST_RST  = ST_PWR;
   localparam logic [CNT_W-1:0] CNT_RST = LD_PWR;
`else
   localparam lcd_state_e       ST_RST  = ST_IDLE;
   localparam logic [CNT_W-1:0] CNT_RST = '0;
`endif

   lcd_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_val;
   logic             cnt_ld, cnt_tc;
   logic             rs_q, lo_q;
   logic [7:0]       dat_q;
   logic             accept, lo_set;
   logic             nib_load, nib_rs, strobe;
   logic [3:0]       nib_val;
`ifdef LCD_SEQ_INIT_EN
   logic             init_q;
   logic [1:0]       init_idx;
   logic             init_step, init_done;
`endif

   assign cnt_tc     = (cnt == '0);
   assign host.ready = (state == ST_IDLE);
   assign lcd_rw     = 1'b0;
   // lcd_e is registered from the next state so it is high exactly in EH.
   assign strobe     = (state_nxt == ST_EH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RST;
         cnt   <= CNT_RST;
         rs_q  <= 1'b0;
         dat_q <= 8'h00;
         lo_q  <= 1'b0;
`ifdef LCD_SEQ_INIT_EN
         init_q   <= 1'b1;
         init_idx <= 2'd0;
`endif
      end else begin
         state <= state_nxt;
         if (cnt_ld) begin
            cnt <= cnt_val;
         end else if (!cnt_tc) begin
            cnt <= cnt - 1'b1;
         end
         if (accept) begin
            rs_q  <= host.rs_in;
            dat_q <= host.data;
            lo_q  <= 1'b0;
         end else if (lo_set) begin
            lo_q <= 1'b1;
         end
`ifdef LCD_SEQ_INIT_EN
         if (init_step) init_idx <= init_idx + 2'd1;
         if (init_done) init_q <= 1'b0;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_ld    = 1'b0;
      cnt_val   = '0;
      accept    = 1'b0;
      lo_set    = 1'b0;
      nib_load  = 1'b0;
      nib_rs    = rs_q;
      nib_val   = dat_q[3:0];
`ifdef LCD_SEQ_INIT_EN
      init_step = 1'b0;
      init_done = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            if (host.req) begin
               accept    = 1'b1;
               nib_load  = 1'b1;
               nib_rs    = host.rs_in;
               nib_val   = host.data[7:4];
               state_nxt = ST_SU;
               cnt_ld    = 1'b1;
               cnt_val   = LD_SU;
            end
         end
         ST_SU: begin
            if (cnt_tc) begin
               state_nxt = ST_EH;
               cnt_ld    = 1'b1;
               cnt_val   = LD_EH;
            end
         end
         ST_EH: begin
            if (cnt_tc) begin
               cnt_ld = 1'b1;
`ifdef LCD_SEQ_INIT_EN
               if (init_q) begin
                  state_nxt = ST_INIT;
                  cnt_val   = LD_INIT;
               end else
`endif
               if (!lo_q) begin
                  state_nxt = ST_GAP;
                  cnt_val   = LD_NIB;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_val   = is_clr_home(rs_q, dat_q) ? LD_CLR : LD_CMD;
               end
            end
         end
         ST_GAP: begin
            if (cnt_tc) begin
               lo_set    = 1'b1;
               nib_load  = 1'b1;
               state_nxt = ST_SU;
               cnt_ld    = 1'b1;
               cnt_val   = LD_SU;
            end
         end
         ST_WAIT: begin
            if (cnt_tc) state_nxt = ST_IDLE;
         end
`ifdef LCD_SEQ_INIT_EN
         ST_PWR: begin
            if (cnt_tc) begin
               nib_load  = 1'b1;
               nib_rs    = 1'b0;
               nib_val   = init_nib(2'd0);
               state_nxt = ST_SU;
               cnt_ld    = 1'b1;
               cnt_val   = LD_SU;
            end
         end
         ST_INIT: begin
            if (cnt_tc) begin
               if (init_idx == 2'(INIT_NIBS - 1)) begin
                  init_done = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  init_step = 1'b1;
                  nib_load  = 1'b1;
                  nib_rs    = 1'b0;
                  nib_val   = init_nib(init_idx + 2'd1);
                  state_nxt = ST_SU;
                  cnt_ld    = 1'b1;
                  cnt_val   = LD_SU;
               end
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   lcd_nib_tx u_nib_tx (
      .clk     (clk),
      .rst     (rst),
      .load    (nib_load),
      .rs_nxt  (nib_rs),
      .nib_nxt (nib_val),
      .strobe  (strobe),
      .lcd_e   (lcd_e),
      .lcd_rs  (lcd_rs),
      .lcd_db  (lcd_db)
   );

endmodule

// File: tb/tb_lcd_seq.sv
// tb_lcd_seq
//   Randomized scoreboard bench for lcd_seq. The stimulus pushes each
//   accepted {rs, byte} into a queue; a monitor watching the LCD pins pops
//   it at each byte's first enable pulse and checks nibble values, enable
//   width, nibble gap, setup/hold and the post-byte wait.
//   Define LCD_SEQ_INIT_EN to exercise the power-on init sequence.
`timescale 1ns/1ps
module tb_lcd_seq;

   localparam int T_SU   = 2;
   localparam int T_EH   = 8;
   localparam int T_NIB  = 27;
   localparam int T_CMD  = 1080;
   localparam int T_CLR  = 44280;
`ifdef LCD_SEQ_INIT_EN
   localparam int T_PWR  = 100;
   localparam int T_INIT = 100;
`endif
   localparam int BUDGET = 60000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcd_e, lcd_rw, lcd_rs;
   logic [3:0] lcd_db;

   lcd_seq_if bus();

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   bit         mon_en = 1'b0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

`ifdef LCD_SEQ_INIT_EN
   lcd_seq #(.T_PWR(T_PWR), .T_INIT(T_INIT)) dut (
`else
   lcd_seq dut (
`endif
      .clk    (clk),
      .rst    (rst),
      .host   (bus.slave),
      .lcd_e  (lcd_e),
      .lcd_rw (lcd_rw),
      .lcd_rs (lcd_rs),
      .lcd_db (lcd_db)
   );

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic expired(input string nm);
      total++;
      bad++;
      $display("FAIL %s: no response within %0d cycles", nm, BUDGET);
   endtask

   task automatic wait_e(input logic lvl, input string nm, output int n);
      n = 0;
      while (lcd_e !== lvl && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (lcd_e !== lvl) expired(nm);
   endtask

   task automatic wait_ready(input string nm, output int n);
      n = 0;
      while (bus.ready !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (bus.ready !== 1'b1) expired(nm);
   endtask

   // Present a byte and hold it until taken; the byte is committed at the
   // posedge following the negedge where ready is seen high.
   task automatic send_byte(input logic rs, input logic [7:0] d, input bit keep);
      int n;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.rs_in = rs;
      bus.data  = d;
      wait_ready("accept", n);
      if (bus.ready === 1'b1) exp_q.push_back({rs, d});
      @(negedge clk);
      if (!keep) bus.req = 1'b0;
   endtask

   // Monitor / scoreboard
   logic       e_d = 1'b0;
   logic [4:0] prev_io = '0, io_rise = '0, io;
   logic [8:0] cur = '0;
   int         stab = 0, rise_c = 0, fall_c = 0, nib_no = 0, wait_exp = 0, st;
   bit         wait_pend = 1'b0;

   always @(negedge clk) begin
      io = {lcd_rs, lcd_db};
      cyc++;
      if (rst) begin
         nib_no    = 0;
         wait_pend = 1'b0;
         exp_q.delete();
      end else if (mon_en) begin
         if (lcd_e && !e_d) begin
            st = (io == prev_io) ? stab : 0;
            chk("setup", (st >= T_SU) ? T_SU : st, T_SU);
            chk("busy_ready", int'(bus.ready), 0);
            io_rise = io;
            rise_c  = cyc;
            if (nib_no == 0) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_strobe: actual db=%0d rs=%0d required none", lcd_db, lcd_rs);
                  cur = '0;
               end else begin
                  cur = exp_q.pop_front();
               end
               chk("hi_rs", int'(lcd_rs), int'(cur[8]));
               chk("hi_nib", int'(lcd_db), int'(cur[7:4]));
            end else begin
               chk("nib_gap", cyc - fall_c, T_NIB + T_SU);
               chk("lo_rs", int'(lcd_rs), int'(cur[8]));
               chk("lo_nib", int'(lcd_db), int'(cur[3:0]));
            end
         end
         if (!lcd_e && e_d) begin
            chk("e_width", cyc - rise_c, T_EH);
            chk("hold", int'(io), int'(io_rise));
            fall_c = cyc;
            if (nib_no == 0) begin
               nib_no = 1;
            end else begin
               nib_no    = 0;
               wait_pend = 1'b1;
               wait_exp  = (!cur[8] && cur[7:0] < 8'd4) ? T_CLR : T_CMD;
            end
         end
         if (wait_pend && bus.ready) begin
            chk("post_wait", cyc - fall_c, wait_exp);
            wait_pend = 1'b0;
         end
      end
      stab    = (io == prev_io) ? stab + 1 : 1;
      prev_io = io;
      e_d     = rst ? 1'b0 : lcd_e;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       r;
      logic [7:0] d;
      int         n;
      bus.req   = 1'b0;
      bus.rs_in = 1'b0;
      bus.data  = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_e", int'(lcd_e), 0);
      chk("rst_rw", int'(lcd_rw), 0);
      chk("rst_rs", int'(lcd_rs), 0);
      chk("rst_db", int'(lcd_db), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
`ifdef LCD_SEQ_INIT_EN
      chk("init_not_ready", int'(bus.ready), 0);
      // A request during init must be ignored: rs = 1 would show on lcd_rs.
      bus.req   = 1'b1;
      bus.rs_in = 1'b1;
      bus.data  = 8'hFF;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         wait_e(1'b1, "init_rise", n);
         chk("init_nib", int'(lcd_db), (i == 3) ? 2 : 3);
         chk("init_rs", int'(lcd_rs), 0);
         chk("init_ready", int'(bus.ready), 0);
         wait_e(1'b0, "init_fall", n);
      end
      bus.req = 1'b0;
      wait_ready("init_done", n);
      chk("init_wait", n, T_INIT);
`else
      chk("ready_after_rst", int'(bus.ready), 1);
`endif
      mon_en = 1'b1;

      send_byte(1'b1, 8'h41, 1'b0);
      send_byte(1'b0, 8'h01, 1'b0);
      send_byte(1'b0, 8'h0C, 1'b0);

      // req held high; the byte shown while busy must never be sent.
      send_byte(1'b0, 8'h28, 1'b1);
      bus.rs_in = 1'b1;
      bus.data  = 8'hAA;
      repeat (200) @(negedge clk);
      send_byte(1'b1, 8'h55, 1'b0);

      for (int i = 0; i < 10; i++) begin
         r = 1'($urandom_range(0, 1));
         d = 8'($urandom_range(0, 255));
         if (!r && d < 8'd4) d = d | 8'h10;
         send_byte(r, d, 1'b0);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
      end

`ifndef LCD_SEQ_INIT_EN
      // Reset during the low-nibble enable pulse.
      send_byte(1'b1, 8'h48, 1'b0);
      wait_e(1'b1, "abort_hi_rise", n);
      wait_e(1'b0, "abort_hi_fall", n);
      wait_e(1'b1, "abort_lo_rise", n);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_e", int'(lcd_e), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_e", int'(lcd_e), 0);
      chk("abort_rs", int'(lcd_rs), 0);
      chk("abort_db", int'(lcd_db), 0);
      chk("abort_rw", int'(lcd_rw), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_ready", int'(bus.ready), 1);
      chk("abort_e_idle", int'(lcd_e), 0);
      send_byte(1'b0, 8'h80, 1'b0);
`endif

      n = 0;
      while (!(exp_q.size() == 0 && !wait_pend && bus.ready) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drained", exp_q.size(), 0);
      chk("wait_done", int'(wait_pend), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
